// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared types and default widths for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } out_state_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for ram_fifo_ctrl.
interface ram_fifo_ctrl_if
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  flush;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH:0]   level;
    logic                  full;
    logic                  empty;

    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, level, full, empty
    );

    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, level, full, empty
    );
endinterface

// File: rtl/my_ram.sv
// Simple dual-port RAM: port A writes, port B reads with a registered output.
module my_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  clkb,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            r_mem[addra] <= dina;
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            doutb <= r_mem[addrb];
        end
    end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a dual-port RAM; the RAM read register is the output stage.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic           clock,
    input  logic           reset_n,
    ram_fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ZERO_C  = '0;

    out_state_t            r_state;
    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;

    logic                  w_full;
    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_has;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_full     = (r_cnt == DEPTH_C);
    assign w_in_ready = !w_full && !bus.flush;
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = r_out_valid && bus.out_ready && !bus.flush;
    assign w_has      = (r_cnt != ZERO_C);
    // Refill the output register when it is empty or being consumed.
    assign w_rd       = !bus.flush && w_has &&
                        ((r_state == ST_EMPTY) || w_pop);

    assign bus.in_ready  = w_in_ready;
    assign bus.full      = w_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_rd_data;
    assign bus.level     = r_cnt + {{ADDR_WIDTH{1'b0}}, r_out_valid};
    assign bus.empty     = (bus.level == ZERO_C);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_has) begin
                        r_state     <= ST_VALID;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (w_pop && !w_has) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    my_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clka  (clock),
        .ena   (1'b1),
        .wea   (w_push),
        .addra (r_wr_ptr),
        .dina  (bus.in_data),
        .clkb  (clock),
        .enb   (w_rd),
        .addrb (r_rd_ptr),
        .doutb (w_rd_data)
    );
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed self-checking bench for ram_fifo_ctrl (DATA_WIDTH=8, ADDR_WIDTH=4).
module tb_ram_fifo_ctrl;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    ram_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    ram_fifo_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.level !== 5'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: ov=%b em=%b fu=%b lv=%0d ir=%b want 0 1 0 0 1",
                     bus.out_valid, bus.empty, bus.full, bus.level, bus.in_ready);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL single_e0: ov=%b lv=%0d want 0 1", bus.out_valid, bus.level);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL single_e1: ov=%b d=%h lv=%0d want 1 a5 1",
                     bus.out_valid, bus.out_data, bus.level);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: em=%b ov=%b want 1 0", bus.empty, bus.out_valid);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 17; i++) begin
            bus.in_data  = 8'(i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.level !== 5'd17) begin
            errors++;
            $display("FAIL fill: fu=%b ir=%b lv=%0d want 1 0 17",
                     bus.full, bus.in_ready, bus.level);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
                errors++;
                $display("FAIL drain[%0d]: ov=%b d=%h want 1 %h",
                         i, bus.out_valid, bus.out_data, 8'(i));
            end
            tick();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
            errors++;
            $display("FAIL drain_end: em=%b lv=%0d want 1 0", bus.empty, bus.level);
        end
    endtask

    task automatic test_stream();
        int wr_n;
        int rd_n;
        wr_n = 0;
        rd_n = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = 8'(8'h40 + wr_n);
            bus.in_valid = 1'b1;
            wr_n++;
            tick();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.level !== 5'd3 ||
                bus.out_data !== 8'(8'h40 + rd_n)) begin
                errors++;
                $display("FAIL stream[%0d]: ov=%b lv=%0d d=%h want 1 3 %h",
                         c, bus.out_valid, bus.level, bus.out_data, 8'(8'h40 + rd_n));
            end
            bus.in_data = 8'(8'h40 + wr_n);
            tick();
            wr_n++;
            rd_n++;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h40 + rd_n)) begin
                errors++;
                $display("FAIL stream_tail[%0d]: ov=%b d=%h want 1 %h",
                         i, bus.out_valid, bus.out_data, 8'(8'h40 + rd_n));
            end
            tick();
            rd_n++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL stream_end: em=%b want 1", bus.empty);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) begin
            bus.in_data  = 8'(8'h80 + i);
            bus.in_valid = 1'b1;
            tick();
        end
        checks++;
        if (bus.level !== 5'd9) begin
            errors++;
            $display("FAIL flush_pre: lv=%0d want 9", bus.level);
        end
        bus.in_data = 8'hEE;
        bus.flush   = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: ir=%b want 0", bus.in_ready);
        end
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_post: lv=%0d em=%b ov=%b want 0 1 0",
                     bus.level, bus.empty, bus.out_valid);
        end
        bus.in_data  = 8'h11;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL flush_next: ov=%b d=%h lv=%0d want 1 11 1",
                     bus.out_valid, bus.out_data, bus.level);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_data  = 8'(8'hC0 + i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.level !== 5'd5) begin
            errors++;
            $display("FAIL arst_pre: lv=%0d want 5", bus.level);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.level !== 5'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_now: ov=%b lv=%0d ir=%b want 0 0 1",
                     bus.out_valid, bus.level, bus.in_ready);
        end
        tick();
        reset_n = 1'b1;
        bus.in_data  = 8'h3C;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL arst_first: ov=%b d=%h lv=%0d want 1 3c 1",
                     bus.out_valid, bus.out_data, bus.level);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        bus.flush     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_stream();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
